// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits; macro UART_TX_HOLD_EN adds a one-word hold register.
// Latency: the start bit begins at the first baud_tick after accept; tx_out follows the state by one clock.
// Backpressure: ready is low while a word is pending (or the hold register is full); data_valid without ready is ignored.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  baud_tick,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  ready,
   output logic                  busy,
   output logic                  tx_out
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  stop_cnt;
   logic [DATA_WIDTH-1:0] shift_dat;
   logic                  frame_par_en;
   logic                  frame_par_bit;
   logic                  pending;
   logic                  accept;
   logic                  load;
   logic                  data_last;
   logic                  stop_last;
   logic                  tx_nxt;

`ifdef UART_TX_HOLD_EN
   logic                  hold_vld;
   logic                  hold_par_en;
   logic                  hold_par_typ;
   logic [DATA_WIDTH-1:0] hold_dat;
`endif

   assign accept    = data_valid & ready;
   assign load      = (state != START) && (state_nxt == START);
   assign data_last = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
   assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx_out   <= 1'b1;
      end else begin
         state  <= state_nxt;
         tx_out <= tx_nxt;
         if (baud_tick && state == DATA)
            bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
         if (baud_tick && state == STOP)
            stop_cnt <= stop_last ? 1'b0 : 1'b1;
      end
   end

   // Without the hold register nothing can become pending during STOP, so the
   // STOP -> START path is only ever taken in the hold build.
   always_comb begin
      state_nxt = state;
      if (baud_tick) begin
         case (state)
            IDLE:    if (pending) state_nxt = START;
            START:   state_nxt = DATA;
            DATA:    if (data_last) state_nxt = frame_par_en ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
            STOP:    if (stop_last) state_nxt = pending ? START : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      tx_nxt = 1'b1;
      case (state)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_dat[bit_cnt];
         PARITY:  tx_nxt = frame_par_bit;
         default: tx_nxt = 1'b1;
      endcase
      busy = (state != IDLE) || pending;
`ifdef UART_TX_HOLD_EN
      ready = !hold_vld;
`else
      ready = (state == IDLE) && !pending;
`endif
   end

`ifdef UART_TX_HOLD_EN
   assign pending = hold_vld;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_vld      <= 1'b0;
         hold_dat      <= '0;
         hold_par_en   <= 1'b0;
         hold_par_typ  <= 1'b0;
         shift_dat     <= '0;
         frame_par_en  <= 1'b0;
         frame_par_bit <= 1'b0;
      end else begin
         if (load) begin
            shift_dat     <= hold_dat;
            frame_par_en  <= hold_par_en;
            frame_par_bit <= (^hold_dat) ^ hold_par_typ;
         end
         // A refill in the transfer cycle wins over the clear.
         if (accept) begin
            hold_vld     <= 1'b1;
            hold_dat     <= p_data;
            hold_par_en  <= par_en;
            hold_par_typ <= par_typ;
         end else if (load) begin
            hold_vld <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending       <= 1'b0;
         shift_dat     <= '0;
         frame_par_en  <= 1'b0;
         frame_par_bit <= 1'b0;
      end else if (accept) begin
         pending       <= 1'b1;
         shift_dat     <= p_data;
         frame_par_en  <= par_en;
         frame_par_bit <= (^p_data) ^ par_typ;
      end else if (load) begin
         pending <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: 4-clock bit periods, tx_out sampled mid-period.
module tb_uart_tx_serializer;
   logic       CLK;
   logic       RST;
   logic       baud_tick;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       ready, busy, tx_out;
   logic       ready2, busy2, tx_out2;

   int checks;
   int errors;
   logic smp_tx, smp_busy, smp_ready, smp_tx2, smp_busy2, smp_ready2;

   uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
      .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .p_data(p_data),
      .data_valid(data_valid), .par_en(par_en), .par_typ(par_typ),
      .ready(ready), .busy(busy), .tx_out(tx_out)
   );

   uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
      .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .p_data(p_data),
      .data_valid(data_valid), .par_en(par_en), .par_typ(par_typ),
      .ready(ready2), .busy(busy2), .tx_out(tx_out2)
   );

   always #5 CLK = ~CLK;

   task step_clk(input logic t);
      baud_tick = t;
      @(negedge CLK);
      baud_tick = 1'b0;
   endtask

   task tick_period();
      step_clk(1'b1);
      step_clk(1'b0);
      step_clk(1'b0);
      smp_tx     = tx_out;
      smp_busy   = busy;
      smp_ready  = ready;
      smp_tx2    = tx_out2;
      smp_busy2  = busy2;
      smp_ready2 = ready2;
      step_clk(1'b0);
   endtask

   // Offer one word for one clock, then scramble the inputs so only the latched copy can be sent.
   task offer(input logic [7:0] d, input logic pe, input logic pt, input logic t);
      data_valid = 1'b1;
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      step_clk(t);
      data_valid = 1'b0;
      p_data     = ~d;
      par_en     = ~pe;
      par_typ    = ~pt;
   endtask

   task do_reset();
      RST = 1'b1;
      step_clk(1'b0);
      step_clk(1'b0);
      RST = 1'b0;
   endtask

   task test_reset();
      do_reset();
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      checks++; if (tx_out2 !== 1'b1) begin errors++; $display("FAIL reset_tx2 got %b want 1", tx_out2); end
   endtask

   task test_frame_a5();
      logic [0:11] exp_v;
      exp_v = 12'b0_10100101_0_1_1;
      offer(8'hA5, 1'b1, 1'b0, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL a5_ready_after_accept got %b want 0", ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a5_busy_after_accept got %b want 1", busy); end
      for (int i = 0; i < 12; i++) begin
         tick_period();
         checks++;
         if (smp_tx !== exp_v[i]) begin
            errors++; $display("FAIL a5_bit%0d got %b want %b", i, smp_tx, exp_v[i]);
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", busy); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL a5_ready_end got %b want 1", ready); end
   endtask

   task test_parity_07();
      logic [0:11] exp_odd;
      logic [0:11] exp_even;
      exp_odd  = 12'b0_11100000_0_1_1;
      exp_even = 12'b0_11100000_1_1_1;
      // Tick coincides with accept: the frame must not start on it.
      offer(8'h07, 1'b1, 1'b1, 1'b1);
      step_clk(1'b0);
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL tick_on_accept_tx got %b want 1", tx_out); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tick_on_accept_busy got %b want 1", busy); end
      for (int i = 0; i < 12; i++) begin
         tick_period();
         checks++;
         if (smp_tx !== exp_odd[i]) begin
            errors++; $display("FAIL p07_odd_bit%0d got %b want %b", i, smp_tx, exp_odd[i]);
         end
      end
      offer(8'h07, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick_period();
         checks++;
         if (smp_tx !== exp_even[i]) begin
            errors++; $display("FAIL p07_even_bit%0d got %b want %b", i, smp_tx, exp_even[i]);
         end
      end
   endtask

   task test_two_stop();
      logic [0:11] exp_v;
      exp_v = 12'b0_11111111_1_1_1;
      do_reset();
      offer(8'hFF, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick_period();
         checks++;
         if (smp_tx2 !== exp_v[i]) begin
            errors++; $display("FAIL stop2_bit%0d got %b want %b", i, smp_tx2, exp_v[i]);
         end
         if (i == 10) begin
            checks++; if (smp_busy2 !== 1'b1) begin errors++; $display("FAIL stop2_busy_p11 got %b want 1", smp_busy2); end
            checks++; if (smp_busy !== 1'b0) begin errors++; $display("FAIL stop1_busy_p11 got %b want 0", smp_busy); end
         end
         if (i == 11) begin
            checks++; if (smp_busy2 !== 1'b0) begin errors++; $display("FAIL stop2_busy_p12 got %b want 0", smp_busy2); end
            checks++; if (smp_ready2 !== 1'b1) begin errors++; $display("FAIL stop2_ready_p12 got %b want 1", smp_ready2); end
         end
      end
   endtask

   task test_reset_mid_frame();
      logic [0:11] exp_v;
      exp_v = 12'b0_00111100_1_1_1;
      offer(8'hA5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick_period();
      checks++; if (smp_tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got %b want 0", smp_tx); end
      RST = 1'b1;
      step_clk(1'b0);
      RST = 1'b0;
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got %b want 1", tx_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", ready); end
      offer(8'h3C, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick_period();
         checks++;
         if (smp_tx !== exp_v[i]) begin
            errors++; $display("FAIL after_rst_bit%0d got %b want %b", i, smp_tx, exp_v[i]);
         end
      end
   endtask

`ifndef UART_TX_HOLD_EN
   task test_valid_held();
      logic [0:21] exp_v;
      exp_v = 22'b0_01011010_1_1_0_11000011_1_1;
      data_valid = 1'b1;
      p_data     = 8'h5A;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      step_clk(1'b0);
      for (int p = 1; p <= 22; p++) begin
         for (int c = 0; c < 4; c++) begin
            if (p == 11 && c == 0) begin
               p_data = 8'hC3;
               par_en = 1'b0;
            end else if (!(p == 11 && c == 1)) begin
               p_data = 8'(p * 7 + c * 13);
               par_en = 1'(c);
            end
            if (p == 11 && c == 2) data_valid = 1'b0;
            step_clk(c == 0);
            if (c == 2) begin
               checks++;
               if (tx_out !== exp_v[p-1]) begin
                  errors++; $display("FAIL held_valid_p%0d got %b want %b", p, tx_out, exp_v[p-1]);
               end
            end
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_valid_busy_end got %b want 0", busy); end
   endtask
`endif

   task test_back_to_back();
`ifdef UART_TX_HOLD_EN
      logic [0:20] exp_v;
      exp_v = 21'b0_10001000_1_0_01000100_1_1;
      data_valid = 1'b1;
      p_data     = 8'h11;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      step_clk(1'b0);
      p_data = 8'h22;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", ready); end
      for (int p = 1; p <= 21; p++) begin
         for (int c = 0; c < 4; c++) begin
            if (p == 1 && c == 2) data_valid = 1'b0;
            step_clk(c == 0);
            if (c == 2) begin
               checks++;
               if (tx_out !== exp_v[p-1]) begin
                  errors++; $display("FAIL b2b_hold_p%0d got %b want %b", p, tx_out, exp_v[p-1]);
               end
            end
         end
      end
`else
      logic [0:21] exp_v;
      exp_v = 22'b0_10001000_1_1_0_01000100_1_1;
      data_valid = 1'b1;
      p_data     = 8'h11;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      step_clk(1'b0);
      p_data = 8'h22;
      for (int p = 1; p <= 22; p++) begin
         for (int c = 0; c < 4; c++) begin
            if (p == 11 && c == 2) data_valid = 1'b0;
            step_clk(c == 0);
            if (c == 2) begin
               checks++;
               if (tx_out !== exp_v[p-1]) begin
                  errors++; $display("FAIL b2b_p%0d got %b want %b", p, tx_out, exp_v[p-1]);
               end
               if (p == 5) begin
                  checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b want 0", ready); end
               end
               if (p == 11) begin
                  checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_pending_busy got %b want 1", busy); end
               end
            end
         end
      end
`endif
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
   endtask

   initial begin
      CLK        = 1'b0;
      RST        = 1'b1;
      baud_tick  = 1'b0;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      checks     = 0;
      errors     = 0;
      @(negedge CLK);
      test_reset();
      test_frame_a5();
      test_parity_07();
      test_two_stop();
      test_reset_mid_frame();
`ifndef UART_TX_HOLD_EN
      test_valid_held();
`endif
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port RST, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port baud_tick, input, 1 bit, one-cycle strobe from the external prescaler marking each bit boundary.
REQ-006 SHALL have port p_data, input, DATA_WIDTH bits, parallel word to send.
REQ-007 SHALL have port data_valid, input, 1 bit, asserted when p_data is offered.
REQ-008 SHALL have port par_en, input, 1 bit; 1 inserts a parity bit.
REQ-009 SHALL have port par_typ, input, 1 bit; 0 selects even parity, 1 selects odd.
REQ-010 SHALL have port ready, output, 1 bit; 1 means a word can be accepted this cycle.
REQ-011 SHALL have port busy, output, 1 bit; 1 while a frame is pending or on the line.
REQ-012 SHALL have port tx_out, output, 1 bit, registered serial line, idle high.

Function
REQ-013 SHALL accept a word in any cycle where data_valid and ready are both 1.
REQ-014 SHALL latch p_data, par_en and par_typ together at accept; later input changes SHALL NOT affect that frame.
REQ-015 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL change state only on a cycle with baud_tick=1, so each bit lasts exactly one tick period.
REQ-017 IDLE -> START on baud_tick when a word is pending; otherwise remain in IDLE.
REQ-018 START -> DATA on baud_tick.
REQ-019 DATA SHALL emit DATA_WIDTH bits LSB first, one per tick, using a bit counter that wraps to 0 on exit.
REQ-020 After the last data bit, DATA -> PARITY if the latched par_en=1, else DATA -> STOP.
REQ-021 PARITY -> STOP on baud_tick.
REQ-022 STOP SHALL last STOP_BITS tick periods.
REQ-023 tx_out SHALL be 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE; tx_out is registered, one CLK after the state update.
REQ-024 The parity bit SHALL be the XOR of the latched data bits when even, and its inverse when odd.
REQ-025 Without the hold buffer (see Configuration), ready SHALL be 1 only in IDLE with no word pending.
REQ-026 busy SHALL be 1 whenever the state is not IDLE or a word is pending.
REQ-027 data_valid while ready=0 SHALL be ignored; the word is not latched.
REQ-028 A baud_tick in the same cycle as an accept SHALL NOT start the frame; the start bit begins at the next baud_tick.

Reset
REQ-029 With RST=1 at a CLK edge, the block SHALL enter IDLE, clear the pending flag, hold buffer and bit counter, and drive tx_out=1, busy=0, ready=1.
REQ-030 Reset in mid-frame SHALL abort the frame immediately, with no completion of the stop bit, and discard any held word.

Configuration
REQ-031 Macro UART_TX_HOLD_EN, when defined, SHALL add a one-word hold register in front of the shift register.
REQ-032 With the macro defined, ready SHALL equal "hold register empty", so a word can be accepted during a frame.
REQ-033 With the macro defined, a held word SHALL transfer to the shift register at the baud_tick ending the last stop bit, and the next START SHALL follow with no idle bit.
REQ-034 With the macro defined, a simultaneous accept and transfer SHALL be handled without loss.
REQ-035 Without the macro, REQ-025 applies, and at least one idle tick period SHALL separate consecutive frames.

Verification
REQ-036 DATA_WIDTH=8, STOP_BITS=1, 0xA5, par_en=1, par_typ=0 -> tx_out per tick: 0,1,0,1,0,0,1,0,1,0,1, then idle 1.
REQ-037 0x07, par_en=1, par_typ=1 -> parity bit 0; same word with par_typ=0 -> parity bit 1.
REQ-038 STOP_BITS=2, par_en=0, 0xFF -> 0, eight 1s, then two stop 1s, i.e. 11 tick periods before busy=0.
REQ-039 RST asserted during data bit 3 -> next cycle tx_out=1, busy=0, ready=1; a new word then sends a complete frame.
REQ-040 UART_TX_HOLD_EN defined, 0x11 and 0x22 offered back-to-back -> second accepted while busy, START of 0x22 immediately after the 0x11 stop bit; undefined -> second offer waits for ready=1.
REQ-041 data_valid held high with ready=0 and p_data changing -> only the words present on accept cycles are transmitted.
